// File: rtl/queue_arbiter_if.sv
// -----------------------------------------------------------------------------
// queue_arbiter_if
// Bundles the producer, consumer and queue-side signals of queue_arbiter.
//   req       producer enqueue requests (level), one bit per producer
//   req_data  producer data, producer i at [i*DW +: DW]
//   gnt       one-hot, one-cycle grant pulse
//   pop       consumer dequeue request (level)
//   rsp_valid one-cycle pulse: rsp_data holds a dequeued item
//   rsp_data  dequeued item (straight from q_dout)
//   q_enq     enqueue strobe to the queue
//   q_din     enqueue data to the queue
//   q_deq     dequeue strobe to the queue
//   q_dout    read data from the queue
//   count     shadow occupancy
//   full      count == DEPTH
//   empty     count == 0
// slave  : the arbiter's view.
// master : the view of the surrounding logic (producers, consumer, queue).
// -----------------------------------------------------------------------------
interface queue_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               pop;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               q_enq;
  logic [DW-1:0]      q_din;
  logic               q_deq;
  logic [DW-1:0]      q_dout;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  modport slave (
    input  req, req_data, pop, q_dout,
    output gnt, rsp_valid, rsp_data, q_enq, q_din, q_deq, count, full, empty
  );

  modport master (
    output req, req_data, pop, q_dout,
    input  gnt, rsp_valid, rsp_data, q_enq, q_din, q_deq, count, full, empty
  );
endinterface

// File: rtl/queue_arbiter.sv
// -----------------------------------------------------------------------------
// queue_arbiter
// Round-robin front end for a DEPTH-entry queue that has a single enqueue port
// and no full/empty status of its own. NREQ producers are arbitrated onto the
// enqueue port, consumer dequeues are interleaved so that the queue never sees
// enq and deq in the same cycle, and a shadow occupancy count provides
// full/empty.
// Ports:
//   clk   rising-edge clock
//   nrst  asynchronous active-low reset (shared with the queue)
//   bus   queue_arbiter_if.slave: req/req_data/gnt producer side,
//         pop/rsp_valid/rsp_data consumer side, q_enq/q_din/q_deq/q_dout
//         queue side, count/full/empty status
// The NREQ/DW/DEPTH parameters must match those of the connected interface.
// -----------------------------------------------------------------------------
module queue_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               nrst,
  queue_arbiter_if.slave     bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    OP_DEQ = 1'b0,
    OP_ENQ = 1'b1
  } op_e;

  // First requester strictly after ptr, wrapping modulo NREQ. Returns ptr
  // itself when only ptr requests (the scan reaches it last).
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   ptr);
    logic [PW-1:0] win;
    logic [PW-1:0] ix;
    logic          found;
    int            idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      ix  = PW'(idx);
      if (!found && req[ix]) begin
        win   = ix;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  logic [PW-1:0]   r_ptr;
  op_e             r_last_op;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;
  logic [NREQ-1:0] r_gnt;
  logic            r_q_enq;
  logic [DW-1:0]   r_q_din;
  logic            r_deq_vld_p0;
  logic            r_deq_vld_p1;

  logic            w_enq_ok;
  logic            w_deq_ok;
  logic            w_do_enq;
  logic            w_do_deq;
  logic [PW-1:0]   w_win;
  logic [CW-1:0]   w_count_nxt;

  assign w_enq_ok = (|bus.req) && !r_full;
  assign w_deq_ok = bus.pop && !r_empty;

  // On a conflict the operation opposite to the last issued one wins, which
  // gives strict ENQ/DEQ alternation under sustained contention.
  assign w_do_enq = w_enq_ok && (!w_deq_ok || (r_last_op == OP_DEQ));
  assign w_do_deq = w_deq_ok && (!w_enq_ok || (r_last_op == OP_ENQ));

  assign w_win = rr_pick(bus.req, r_ptr);

  // Eligibility already blocks ENQ at DEPTH and DEQ at 0, so no saturation
  // logic is needed here.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_enq) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_do_deq) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Issue edge: grant/enqueue/dequeue strobes and status registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr        <= PW'(NREQ - 1);
      r_last_op    <= OP_DEQ;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_gnt        <= '0;
      r_q_enq      <= 1'b0;
      r_q_din      <= '0;
      r_deq_vld_p0 <= 1'b0;
      r_deq_vld_p1 <= 1'b0;
    end else begin
      r_q_enq      <= w_do_enq;
      r_deq_vld_p0 <= w_do_deq;
      r_gnt        <= w_do_enq ? (NREQ'(1) << w_win) : '0;
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == CW'(DEPTH));
      r_empty      <= (w_count_nxt == '0);
      if (w_do_enq) begin
        r_q_din   <= bus.req_data[w_win*DW +: DW];
        r_ptr     <= w_win;
        r_last_op <= OP_ENQ;
      end else if (w_do_deq) begin
        r_last_op <= OP_DEQ;
      end
      // Queue read edge: q_dout becomes valid one cycle after q_deq.
      r_deq_vld_p1 <= r_deq_vld_p0;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.q_enq     = r_q_enq;
  assign bus.q_din     = r_q_din;
  assign bus.q_deq     = r_deq_vld_p0;
  assign bus.rsp_valid = r_deq_vld_p1;
  assign bus.rsp_data  = bus.q_dout;
  assign bus.count     = r_count;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;

endmodule

// File: tb/tb_queue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_queue_arbiter
// Bench for queue_arbiter with a behavioural 4-entry queue attached. A vector
// table covers reset, single round trip, fill-to-full and drain; hand-written
// sequences cover fairness, enq/deq conflict and reset during a dequeue. A
// scoreboard records each granted item and compares it on rsp_valid.
// -----------------------------------------------------------------------------
module tb_queue_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int NVEC  = 17;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  queue_arbiter_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus ();

  queue_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Behavioural queue: registered read data, shares the reset.
  logic [DW-1:0] qm_mem [DEPTH];
  logic [DW-1:0] qm_dout;
  int            qm_wr;
  int            qm_rd;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      qm_wr   <= 0;
      qm_rd   <= 0;
      qm_dout <= '0;
    end else begin
      if (bus.q_enq) begin
        qm_mem[qm_wr] <= bus.q_din;
        qm_wr         <= (qm_wr + 1) % DEPTH;
      end
      if (bus.q_deq) begin
        qm_dout <= qm_mem[qm_rd];
        qm_rd   <= (qm_rd + 1) % DEPTH;
      end
    end
  end
  assign bus.q_dout = qm_dout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer data as sampled at each edge, used to predict the granted item.
  logic [NREQ*DW-1:0] cap_data;
  always @(posedge clk) cap_data <= bus.req_data;

  // Per-cycle monitor and scoreboard.
  logic [DW-1:0] sb[$];
  int            tb_cnt;
  logic          prev_deq;
  logic [DW-1:0] sb_exp;
  initial begin
    tb_cnt   = 0;
    prev_deq = 1'b0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        sb.delete();
        tb_cnt   = 0;
        prev_deq = 1'b0;
      end else begin
        check("enq_deq_excl", bus.q_enq & bus.q_deq, 0);
        check("gnt_vs_enq", $countones(bus.gnt), bus.q_enq ? 1 : 0);
        if (bus.q_enq) tb_cnt++;
        if (bus.q_deq) tb_cnt--;
        check("count_track", bus.count, tb_cnt);
        check("full_flag", bus.full, tb_cnt == DEPTH);
        check("empty_flag", bus.empty, tb_cnt == 0);
        check("rsp_after_deq", bus.rsp_valid, prev_deq);
        prev_deq = bus.q_deq;
        if (bus.q_enq) begin
          for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
              check("q_din_sb", bus.q_din, cap_data[i*DW +: DW]);
              sb.push_back(cap_data[i*DW +: DW]);
            end
          end
        end
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
          end else begin
            sb_exp = sb.pop_front();
            check("rsp_data_sb", bus.rsp_data, sb_exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks reset values, releases on a falling edge.
  task automatic do_reset();
    #3 nrst = 1'b0;
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_q_enq", bus.q_enq, 0);
    check("rst_q_deq", bus.q_deq, 0);
    check("rst_q_din", bus.q_din, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    bus.req      = '0;
    bus.req_data = '0;
    bus.pop      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    step();
    check("post_rst_enq", bus.q_enq, 0);
    check("post_rst_deq", bus.q_deq, 0);
  endtask

  typedef struct {
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic               pop;
    logic [NREQ-1:0]    gnt;
    logic               enq;
    logic [DW-1:0]      din;
    logic               deq;
    int                 cnt;
    logic               rv;
    logic [DW-1:0]      rd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [NREQ-1:0] req, logic [NREQ*DW-1:0] data,
                              logic pop, logic [NREQ-1:0] gnt, logic enq, logic [DW-1:0] din,
                              logic deq, int cnt, logic rv, logic [DW-1:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.data = data; v.pop = pop; v.gnt = gnt; v.enq = enq;
    v.din = din; v.deq = deq; v.cnt = cnt; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  vec_t        tbl [NVEC];
  logic [3:0]  fair_exp [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  int          got;

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.pop      = 1'b0;

    //            rst req      data      pop gnt     enq din  deq cnt rv rd
    tbl[0]  = mk(0, 4'b0001, 16'h000A, 0, 4'b0001, 1, 4'hA, 0, 1, 0, 4'h0);
    tbl[1]  = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 0, 0, 4'h0);
    tbl[2]  = mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'h0, 0, 0, 1, 4'hA);
    tbl[3]  = mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'h0, 0, 0, 0, 4'h0);
    tbl[4]  = mk(1, 4'b1111, 16'h4321, 0, 4'b0001, 1, 4'h1, 0, 1, 0, 4'h0);
    tbl[5]  = mk(0, 4'b1110, 16'h4321, 0, 4'b0010, 1, 4'h2, 0, 2, 0, 4'h0);
    tbl[6]  = mk(0, 4'b1100, 16'h4321, 0, 4'b0100, 1, 4'h3, 0, 3, 0, 4'h0);
    tbl[7]  = mk(0, 4'b1000, 16'h4321, 0, 4'b1000, 1, 4'h4, 0, 4, 0, 4'h0);
    tbl[8]  = mk(0, 4'b0001, 16'h000A, 0, 4'b0000, 0, 4'h0, 0, 4, 0, 4'h0);
    tbl[9]  = mk(0, 4'b0001, 16'h000A, 1, 4'b0000, 0, 4'h0, 1, 3, 0, 4'h0);
    tbl[10] = mk(0, 4'b0001, 16'h000A, 0, 4'b0001, 1, 4'hA, 0, 4, 1, 4'h1);
    tbl[11] = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 3, 0, 4'h0);
    tbl[12] = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 2, 1, 4'h2);
    tbl[13] = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 1, 1, 4'h3);
    tbl[14] = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 0, 1, 4'h4);
    tbl[15] = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0, 0, 1, 4'hA);
    tbl[16] = mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'h0, 0, 0, 0, 4'h0);

    do_reset();

    // Round trip, fill to full, blocked fifth request, drain.
    for (int v = 0; v < NVEC; v++) begin
      if (tbl[v].rst) do_reset();
      bus.req      = tbl[v].req;
      bus.req_data = tbl[v].data;
      bus.pop      = tbl[v].pop;
      step();
      check($sformatf("tv%0d_gnt", v), bus.gnt, tbl[v].gnt);
      check($sformatf("tv%0d_enq", v), bus.q_enq, tbl[v].enq);
      check($sformatf("tv%0d_deq", v), bus.q_deq, tbl[v].deq);
      check($sformatf("tv%0d_count", v), bus.count, tbl[v].cnt);
      check($sformatf("tv%0d_full", v), bus.full, tbl[v].cnt == DEPTH);
      check($sformatf("tv%0d_empty", v), bus.empty, tbl[v].cnt == 0);
      check($sformatf("tv%0d_rsp_valid", v), bus.rsp_valid, tbl[v].rv);
      if (tbl[v].enq) check($sformatf("tv%0d_din", v), bus.q_din, tbl[v].din);
      if (tbl[v].rv)  check($sformatf("tv%0d_rsp_data", v), bus.rsp_data, tbl[v].rd);
    end

    // Fairness: producers 0 and 2 held, pop held.
    do_reset();
    bus.req      = 4'b0101;
    bus.req_data = 16'h0605;
    bus.pop      = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      step();
      if (|bus.gnt) begin
        check($sformatf("fair_gnt%0d", got), bus.gnt, fair_exp[got]);
        got++;
      end
    end
    check("fair_grants_seen", got, 4);
    bus.req = '0;
    repeat (6) step();
    bus.pop = 1'b0;
    repeat (3) step();

    // Conflict: three enqueues, one dequeue leaves count=2 with last op DEQ.
    do_reset();
    bus.req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      bus.req_data = 16'((i + 1) << DW);
      step();
      check("cf_pre_gnt", bus.gnt, 4'b0010);
    end
    bus.req = '0;
    bus.pop = 1'b1;
    step();
    check("cf_pre_deq", bus.q_deq, 1);
    check("cf_pre_count", bus.count, 2);
    bus.req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      bus.req_data = 16'((8 + i) << DW);
      step();
      check($sformatf("cf%0d_enq", i), bus.q_enq, (i % 2) == 0);
      check($sformatf("cf%0d_deq", i), bus.q_deq, (i % 2) == 1);
      check($sformatf("cf%0d_count", i), bus.count, ((i % 2) == 0) ? 3 : 2);
    end
    bus.req = '0;
    repeat (5) step();
    check("cf_drained", bus.empty, 1);
    bus.pop = 1'b0;
    repeat (3) step();

    // Reset while a dequeue is in flight: its response must be dropped.
    do_reset();
    bus.req      = 4'b0001;
    bus.req_data = 16'h0003;
    step();
    check("rf_enq", bus.q_enq, 1);
    bus.req = '0;
    bus.pop = 1'b1;
    step();
    check("rf_deq", bus.q_deq, 1);
    bus.pop = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("rf_no_rsp", bus.rsp_valid, 0);
      check("rf_count", bus.count, 0);
      step();
    end
    bus.req      = 4'b0001;
    bus.req_data = 16'h0005;
    step();
    check("rf_rt_gnt", bus.gnt, 4'b0001);
    check("rf_rt_din", bus.q_din, 4'h5);
    check("rf_rt_count", bus.count, 1);
    bus.req = '0;
    bus.pop = 1'b1;
    step();
    check("rf_rt_deq", bus.q_deq, 1);
    bus.pop = 1'b0;
    step();
    check("rf_rt_rsp_valid", bus.rsp_valid, 1);
    check("rf_rt_rsp_data", bus.rsp_data, 4'h5);
    check("rf_rt_empty", bus.empty, 1);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
